// File: rtl/mic_adc_reader.sv
// mic_adc_reader: periodic SPI-style reader for an external serial mic ADC
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           enables the sample timer
//   adc_miso_i     serial data from the ADC
//   adc_sclk_o     serial clock to the ADC, idles low
//   adc_cs_n_o     ADC chip select, active low
//   sample_o       last completed sample
//   sample_valid_o one-cycle pulse when sample_o updates
//   busy_o         conversion in progress
//   overrun_o      sticky: a trigger arrived while busy
module mic_adc_reader #(
   parameter int DATA_W        = 8,
   parameter int LEAD_BITS     = 2,
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              adc_miso_i,
   output logic              adc_sclk_o,
   output logic              adc_cs_n_o,
   output logic [DATA_W-1:0] sample_o,
   output logic              sample_valid_o,
   output logic              busy_o,
   output logic              overrun_o
);
   localparam int NBITS = LEAD_BITS + DATA_W;
   localparam int TW    = $clog2(SAMPLE_PERIOD);
   localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BW    = $clog2(NBITS + 1);
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
   state_t            state_q;
   logic [TW-1:0]     timer_q, timer_d;
   logic [DW-1:0]     div_q;
   logic [BW-1:0]     bit_q;
   logic [DATA_W-1:0] shift_q, sample_q;
   logic              sclk_q, cs_n_q, valid_q, busy_q, ovr_q;
   logic              trig, tick;
   always_comb begin
      trig    = en_i && timer_q == TW'(SAMPLE_PERIOD - 1);
      timer_d = (!en_i || trig) ? '0 : timer_q + 1'b1;
      tick    = div_q == DW'(CLK_DIV - 1);
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) timer_q <= '0;
      else         timer_q <= timer_d;
   // Lead bits need no special handling: they are shifted in first and
   // fall off the top of the DATA_W-wide shift register.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         sample_q <= '0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (trig && state_q != IDLE) ovr_q <= 1'b1;
         case (state_q)
            IDLE:
               if (trig) begin
                  state_q <= SETUP;
                  cs_n_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  div_q   <= '0;
               end
            SETUP: begin
               div_q <= tick ? '0 : div_q + 1'b1;
               if (tick) begin
                  state_q <= SHIFT;
                  bit_q   <= '0;
               end
            end
            SHIFT: begin
               div_q <= tick ? '0 : div_q + 1'b1;
               if (tick) begin
                  sclk_q <= !sclk_q;
                  if (!sclk_q) begin
                     shift_q <= {shift_q[DATA_W-2:0], adc_miso_i};
                     bit_q   <= bit_q + 1'b1;
                  end else if (bit_q == BW'(NBITS)) state_q <= DONE;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               sample_q <= shift_q;
               valid_q  <= 1'b1;
               cs_n_q   <= 1'b1;
               busy_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign adc_sclk_o     = sclk_q;
   assign adc_cs_n_o     = cs_n_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign busy_o         = busy_q;
   assign overrun_o      = ovr_q;
endmodule
